// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: credit accumulator in 50c units, programmable price,
// unit-per-cycle change return, overflow coin rejection, inactivity refund and stock tracking.
module vend_ctrl_param #(
  parameter int unsigned CREDIT_W   = 4,
  parameter int unsigned PRICE      = 2,
  parameter int unsigned MAX_CREDIT = 4,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned STOCK_MAX  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fifty,
  input  logic                dollar,
  input  logic                cancel,
  input  logic                refill,
  output logic                insert_coin,
  output logic                dispense,
  output logic                money_return,
  output logic                coin_reject,
  output logic                sold_out,
  output logic [1:0]          st,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    CHANGE  = 2'b11
  } state_t;

  state_t              state, state_nx;
  logic [CREDIT_W-1:0] credit_nx;
  logic [STOCK_W-1:0]  stock_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic                reject_nx;

  logic                coin_any;
  logic                coin_both;
  logic [SUM_W-1:0]    sum;
  logic                accept;
  logic                reach_price;

  // Coin evaluation: a dollar wins over a simultaneous fifty, which is always rejected.
  assign coin_any    = fifty | dollar;
  assign coin_both   = fifty & dollar;
  assign sum         = SUM_W'(credit) + (dollar ? SUM_W'(2) : SUM_W'(1));
  assign accept      = coin_any && !sold_out && (sum <= SUM_W'(MAX_CREDIT));
  assign reach_price = sum >= SUM_W'(PRICE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      credit      <= '0;
      stock       <= STOCK_W'(STOCK_MAX);
      cnt         <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nx;
      credit      <= credit_nx;
      stock       <= stock_nx;
      cnt         <= cnt_nx;
      coin_reject <= reject_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    stock_nx  = stock;
    cnt_nx    = cnt;
    reject_nx = 1'b0;
    case (state)
      IDLE: begin
        if (refill) stock_nx = STOCK_W'(STOCK_MAX);
        reject_nx = coin_both | (coin_any & ~accept);
        if (accept) begin
          credit_nx = CREDIT_W'(sum);
          cnt_nx    = '0;
          state_nx  = reach_price ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        if (cancel) begin
          state_nx  = CHANGE;
          reject_nx = coin_any;
        end else if (accept) begin
          credit_nx = CREDIT_W'(sum);
          cnt_nx    = '0;
          reject_nx = coin_both;
          if (reach_price) state_nx = VEND;
        end else begin
          reject_nx = coin_any;
          if (cnt == CNT_W'(TIMEOUT - 1)) state_nx = CHANGE;
          else cnt_nx = cnt + CNT_W'(1);
        end
      end
      VEND: begin
        reject_nx = coin_any;
        credit_nx = credit - CREDIT_W'(PRICE);
        stock_nx  = stock - STOCK_W'(1);
        state_nx  = (credit > CREDIT_W'(PRICE)) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_nx = coin_any;
        credit_nx = credit - CREDIT_W'(1);
        if (credit <= CREDIT_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign st           = state;
  assign insert_coin  = (state == COLLECT);
  assign dispense     = (state == VEND);
  assign money_return = (state == CHANGE);
  assign sold_out     = (stock == '0);

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param at default parameters.
module tb_vend_ctrl_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifty, dollar, cancel, refill;
  logic       insert_coin, dispense, money_return, coin_reject, sold_out;
  logic [1:0] st;
  logic [3:0] credit;
  logic [3:0] stock;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_IDLE = 2'b00, S_COLLECT = 2'b01, S_VEND = 2'b10, S_CHANGE = 2'b11;

  vend_ctrl_param dut (
    .clk(clk), .rst(rst), .fifty(fifty), .dollar(dollar), .cancel(cancel), .refill(refill),
    .insert_coin(insert_coin), .dispense(dispense), .money_return(money_return),
    .coin_reject(coin_reject), .sold_out(sold_out), .st(st), .credit(credit), .stock(stock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic d, input logic c, input logic r);
    fifty = f; dollar = d; cancel = c; refill = r;
  endtask

  task automatic check_state(input string tag, input logic [1:0] es, input logic [3:0] ec);
    check({tag, "_st"}, 32'(st), 32'(es));
    check({tag, "_credit"}, 32'(credit), 32'(ec));
    check({tag, "_insert"}, 32'(insert_coin), 32'(es == S_COLLECT));
    check({tag, "_dispense"}, 32'(dispense), 32'(es == S_VEND));
    check({tag, "_return"}, 32'(money_return), 32'(es == S_CHANGE));
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    check_state("reset", S_IDLE, 4'd0);
    check("reset_stock", 32'(stock), 32'd10);
    check("reset_sold_out", 32'(sold_out), 32'd0);
    check("reset_reject", 32'(coin_reject), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Two fifties: collect then vend, no change.
    drive(1, 0, 0, 0); tick();
    check_state("ff_1", S_COLLECT, 4'd1);
    tick();
    check_state("ff_vend", S_VEND, 4'd2);
    drive(0, 0, 0, 0); tick();
    check_state("ff_done", S_IDLE, 4'd0);
    check("ff_stock", 32'(stock), 32'd9);

    // Fifty then dollar: overpay by one unit, one change cycle.
    drive(1, 0, 0, 0); tick();
    check_state("fd_1", S_COLLECT, 4'd1);
    drive(0, 1, 0, 0); tick();
    check_state("fd_vend", S_VEND, 4'd3);
    drive(0, 0, 0, 0); tick();
    check_state("fd_change", S_CHANGE, 4'd1);
    check("fd_stock", 32'(stock), 32'd8);
    tick();
    check_state("fd_done", S_IDLE, 4'd0);

    // Cancel with same-cycle coin: coin rejected, refund one unit.
    drive(1, 0, 0, 0); tick();
    check_state("cx_1", S_COLLECT, 4'd1);
    drive(1, 0, 1, 0); tick();
    check_state("cx_change", S_CHANGE, 4'd1);
    check("cx_reject", 32'(coin_reject), 32'd1);
    drive(0, 0, 0, 0); tick();
    check_state("cx_done", S_IDLE, 4'd0);
    check("cx_reject_clr", 32'(coin_reject), 32'd0);
    check("cx_stock", 32'(stock), 32'd8);

    // Inactivity timeout: 16 idle COLLECT cycles then refund.
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 15; i++) tick();
    check_state("to_still", S_COLLECT, 4'd1);
    tick();
    check_state("to_change", S_CHANGE, 4'd1);
    tick();
    check_state("to_done", S_IDLE, 4'd0);

    // Simultaneous coins: dollar taken, fifty rejected; coin during VEND rejected.
    drive(1, 1, 0, 0); tick();
    check_state("both_vend", S_VEND, 4'd2);
    check("both_reject", 32'(coin_reject), 32'd1);
    drive(1, 0, 0, 0); tick();
    check_state("vendcoin_idle", S_IDLE, 4'd0);
    check("vendcoin_reject", 32'(coin_reject), 32'd1);
    check("vendcoin_stock", 32'(stock), 32'd7);
    drive(0, 0, 0, 0); tick();
    check("reject_pulse_end", 32'(coin_reject), 32'd0);

    // Drain remaining stock with dollars, then sold-out behaviour and refill.
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 0); tick();
      drive(0, 0, 0, 0); tick();
    end
    check("drain_stock", 32'(stock), 32'd0);
    check("drain_sold_out", 32'(sold_out), 32'd1);
    drive(1, 0, 0, 0); tick();
    check_state("so_coin", S_IDLE, 4'd0);
    check("so_reject", 32'(coin_reject), 32'd1);
    drive(0, 0, 0, 1); tick();
    check("refill_stock", 32'(stock), 32'd10);
    check("refill_sold_out", 32'(sold_out), 32'd0);
    drive(0, 0, 0, 0); tick();

    // Async reset in the middle of CHANGE: immediate return to IDLE, no refund.
    drive(1, 0, 0, 0); tick();
    drive(0, 1, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    check_state("rc_change", S_CHANGE, 4'd1);
    check("rc_stock", 32'(stock), 32'd9);
    #2 rst = 1'b0;
    #1;
    check_state("rc_async", S_IDLE, 4'd0);
    check("rc_stock_reset", 32'(stock), 32'd10);
    tick();
    rst = 1'b1;
    tick();
    check_state("rc_after", S_IDLE, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
